// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// divider sizing, plus a small magnitude helper used by the divider.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // Magnitude of a 32-bit operand; only negated when the op is signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage <-> MDU bus: issue request, cancel, and HI/LO write port.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic [1:0]  hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;

  modport master (
    output start, op, a, b, flush,
    input  stall, hilo_we, hi_wdata, lo_wdata, busy
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, hilo_we, hi_wdata, lo_wdata, busy
  );
endinterface

// File: rtl/mdu_div_radix2.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
// valid is raised during the final iteration; quotient/remainder then carry
// the sign-corrected result of that iteration so the caller latches it on
// the same edge.
module div_radix2
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0]      rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, neg_quo_q, neg_rem_q;

  logic [32:0] partial, diff;
  logic        fits;
  logic [31:0] rem_n, quo_n;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dvs_q};
    fits    = ~diff[32];
    rem_n   = fits ? diff[31:0] : partial[31:0];
    quo_n   = {quo_q[30:0], fits};
    valid   = run_q && (cnt_q == CNT_W'(DIV_ITERS - 1));
    quotient  = neg_quo_q ? (32'd0 - quo_n) : quo_n;
    remainder = neg_rem_q ? (32'd0 - rem_n) : rem_n;
  end

  // Operand capture on start, then iterate until the last step or an abort.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= abs32(a, signed_op);
      dvs_q     <= abs32(b, signed_op);
      cnt_q     <= '0;
      run_q     <= 1'b1;
      neg_quo_q <= signed_op & (a[31] ^ b[31]);
      neg_rem_q <= signed_op & a[31];
    end else if (run_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (abort || valid) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: accepts ops in IDLE, runs a one-cycle
// multiply or a 32-step divide, and writes HI/LO in a single DONE cycle.
// MTHI/MTLO bypass the FSM and write combinationally in IDLE.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  mdu_if.slave  bus
);

  state_e      state;
  logic [31:0] a_q, b_q;
  logic        signed_q;
  logic [31:0] res_hi, res_lo;

  op_e         op_in;
  logic        take, is_mul, is_div, div_zero, div_go;
  logic [63:0] product;

  logic [31:0] div_quo, div_rem;
  logic        div_valid;

  // Decode of the request; a flush in IDLE cancels acceptance outright.
  always_comb begin
    op_in    = op_e'(bus.op);
    take     = (state == ST_IDLE) && bus.start && !bus.flush;
    is_mul   = take && ((op_in == OP_MULT) || (op_in == OP_MULTU));
    is_div   = take && ((op_in == OP_DIV)  || (op_in == OP_DIVU));
    div_zero = is_div && (bus.b == 32'd0);
    div_go   = is_div && (bus.b != 32'd0);
  end

  // 64-bit product from the latched operands; sign-extend for MULT.
  always_comb begin
    if (signed_q)
      product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      product = {32'd0, a_q} * {32'd0, b_q};
  end

  div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_go),
    .abort     (bus.flush),
    .a         (bus.a),
    .b         (bus.b),
    .signed_op (op_in == OP_DIV),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Pipeline handshake and HI/LO write port.
  always_comb begin
    bus.stall    = is_mul || is_div || (state == ST_MUL) || (state == ST_DIV);
    bus.busy     = (state == ST_MUL) || (state == ST_DIV);
    bus.hilo_we  = 2'b00;
    bus.hi_wdata = 32'd0;
    bus.lo_wdata = 32'd0;
    if (take && (op_in == OP_MTHI)) begin
      bus.hilo_we  = 2'b10;
      bus.hi_wdata = bus.a;
    end else if (take && (op_in == OP_MTLO)) begin
      bus.hilo_we  = 2'b01;
      bus.lo_wdata = bus.a;
    end else if (state == ST_DONE) begin
      bus.hilo_we  = bus.flush ? 2'b00 : 2'b11;
      bus.hi_wdata = res_hi;
      bus.lo_wdata = res_lo;
    end
  end

  // FSM with operand and result capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: result registers are cleared on reset so HI/LO data is defined before the first op.
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mul) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            signed_q <= (op_in == OP_MULT);
            state    <= ST_MUL;
          end else if (div_zero) begin
            res_hi <= bus.a;
            res_lo <= 32'hFFFF_FFFF;
            state  <= ST_DONE;
          end else if (div_go) begin
            state <= ST_DIV;
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else begin
            res_hi <= product[63:32];
            res_lo <= product[31:0];
            state  <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (div_valid) begin
            res_hi <= div_rem;
            res_lo <= div_quo;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset values, MT bypass, multiply, divide,
// divide-by-zero, flush and reset aborts, DONE-cycle behaviour.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdu_if mif ();

  mdu_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (mif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op, count stall cycles, then check the DONE-cycle write.
  // poke presents an ignored start in DONE; flsh flushes the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit poke, input bit flsh);
    int n = 0;
    bit we_seen = 0;
    mif.start = 1'b1; mif.op = o; mif.a = av; mif.b = bv;
    #1;
    while (mif.stall && n < 100) begin
      if (mif.hilo_we != 2'b00) we_seen = 1;
      step();
      mif.start = 1'b0; mif.a = 32'hDEAD_BEEF; mif.b = 32'h1234_5677;
      #1;
      n++;
    end
    check({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
    check({tag, " we_during_stall"}, 64'(we_seen), 64'd0);
    if (poke) begin
      mif.start = 1'b1; mif.op = OP_MULT; mif.a = 32'd7; mif.b = 32'd9;
    end
    if (flsh) mif.flush = 1'b1;
    #1;
    if (flsh) begin
      check({tag, " done_we_flushed"}, 64'(mif.hilo_we), 64'd0);
    end else begin
      check({tag, " done_we"}, 64'(mif.hilo_we), 64'd3);
      check({tag, " hi"}, 64'(mif.hi_wdata), 64'(exp_hi));
      check({tag, " lo"}, 64'(mif.lo_wdata), 64'(exp_lo));
    end
    check({tag, " done_stall"}, 64'(mif.stall), 64'd0);
    step();
    mif.start = 1'b0; mif.flush = 1'b0;
    #1;
    check({tag, " after_busy"}, 64'(mif.busy), 64'd0);
    check({tag, " after_we"}, 64'(mif.hilo_we), 64'd0);
  endtask

  // Watch a span of cycles with start low; no write may appear.
  task automatic quiet(input string tag, input int cycles);
    bit we_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (mif.hilo_we != 2'b00) we_seen = 1;
    end
    check({tag, " no_write"}, 64'(we_seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    mif.start = 1'b0; mif.op = 3'b000; mif.a = '0; mif.b = '0; mif.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("reset stall", 64'(mif.stall), 64'd0);
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset we", 64'(mif.hilo_we), 64'd0);
    check("reset hi", 64'(mif.hi_wdata), 64'd0);
    check("reset lo", 64'(mif.lo_wdata), 64'd0);

    // MT bypass, flush in IDLE, NOP/reserved op.
    step();
    mif.start = 1'b1; mif.op = OP_MTHI; mif.a = 32'h1234_5678; #1;
    check("mthi we", 64'(mif.hilo_we), 64'd2);
    check("mthi hi", 64'(mif.hi_wdata), 64'h1234_5678);
    check("mthi stall", 64'(mif.stall), 64'd0);
    mif.op = OP_MTLO; mif.a = 32'hCAFE_F00D; #1;
    check("mtlo we", 64'(mif.hilo_we), 64'd1);
    check("mtlo lo", 64'(mif.lo_wdata), 64'hCAFE_F00D);
    mif.flush = 1'b1; #1;
    check("mtlo flushed we", 64'(mif.hilo_we), 64'd0);
    mif.op = OP_MULT; #1;
    check("mult flushed stall", 64'(mif.stall), 64'd0);
    step();
    mif.flush = 1'b0; mif.op = OP_NOP; #1;
    check("flushed mult not taken", 64'(mif.busy), 64'd0);
    check("nop stall", 64'(mif.stall), 64'd0);
    check("nop we", 64'(mif.hilo_we), 64'd0);
    mif.op = OP_RSVD; #1;
    check("op7 stall", 64'(mif.stall), 64'd0);
    check("op7 we", 64'(mif.hilo_we), 64'd0);
    step();
    mif.start = 1'b0; #1;
    check("op7 not taken", 64'(mif.busy), 64'd0);

    // Multiply.
    run_op("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
    run_op("mult minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'h0, 1'b0, 1'b0);

    // Divide.
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1'b0);
    run_op("divu max/16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, 32'h0FFF_FFFF, 1'b1, 1'b0);
    run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div -3/0", OP_DIV, 32'hFFFF_FFFD, 32'd0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Flush in DONE suppresses the write.
    run_op("multu flushdone", OP_MULTU, 32'd6, 32'd7, 2, 32'd0, 32'd42, 1'b0, 1'b1);

    // Flush at DIV iteration 10.
    mif.start = 1'b1; mif.op = OP_DIV; mif.a = 32'd1000; mif.b = 32'd3;
    step();
    mif.start = 1'b0;
    repeat (9) step();
    mif.flush = 1'b1; #1;
    check("flush iter10 stall", 64'(mif.stall), 64'd1);
    check("flush iter10 we", 64'(mif.hilo_we), 64'd0);
    step();
    mif.flush = 1'b0; #1;
    check("after flush stall", 64'(mif.stall), 64'd0);
    check("after flush busy", 64'(mif.busy), 64'd0);
    quiet("after flush", 40);
    run_op("multu 3*4", OP_MULTU, 32'd3, 32'd4, 2, 32'd0, 32'd12, 1'b0, 1'b0);

    // Reset at DIV iteration 20.
    mif.start = 1'b1; mif.op = OP_DIVU; mif.a = 32'd12345; mif.b = 32'd11;
    step();
    mif.start = 1'b0;
    repeat (19) step();
    check("iter20 busy", 64'(mif.busy), 64'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1; #1;
    check("midreset stall", 64'(mif.stall), 64'd0);
    check("midreset busy", 64'(mif.busy), 64'd0);
    check("midreset we", 64'(mif.hilo_we), 64'd0);
    check("midreset hi", 64'(mif.hi_wdata), 64'd0);
    check("midreset lo", 64'(mif.lo_wdata), 64'd0);
    quiet("after reset", 40);
    run_op("divu 100/7 again", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
